spike_rate_decoder: RTL
=======================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter M, default 5: fast-rate period base (input 1 produces inter-spike intervals M-1..M).
REQ-002 Parameter N, default 10: slow-rate period base (input 0 produces inter-spike intervals N-1..N).
REQ-003 Parameter THRESH, default 7: interval at or below THRESH decodes as 1, above decodes as 0.
REQ-004 Parameter TIMEOUT, default 20: cycles without a spike before lock is dropped; SHALL satisfy N < TIMEOUT < 31.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 spikeInput  input  1  spike train, one-cycle-high pulses, sampled every rising edge.
REQ-008 clearError  input  1  synchronous clear of errorFlag.
REQ-009 decodedValue  output  1  majority-decoded bit.
REQ-010 valid  output  1  one-cycle pulse when decodedValue is updated.
REQ-011 locked  output  1  high in LOCKED state.
REQ-012 isiCount  output  5  last accepted inter-spike interval in cycles.
REQ-013 errorFlag  output  1  sticky out-of-range interval indicator.

Function
REQ-014 Interval counter cnt (5 bits): on a spike cycle cnt <= 1; otherwise cnt <= cnt+1, saturating at 31; held at 0 in IDLE.
REQ-015 Measured interval on a spike = cnt value before update (spikes at cycles t0, t1 give interval t1-t0).
REQ-016 Interval accepted iff M-1 <= interval <= N; classified bit = 1 if interval <= THRESH, else 0.
REQ-017 Rejected interval: errorFlag set, history, sample count and isiCount unchanged, state unchanged, cnt restarts at 1.
REQ-018 Accepted interval: isiCount <= interval; bit shifted into 3-bit history; sample count increments, saturating at 3.
REQ-019 States: IDLE, ACQUIRE, LOCKED; encoded as 2-bit register.
REQ-020 IDLE: first spike -> ACQUIRE, cnt <= 1, history and sample count cleared; no interval evaluated.
REQ-021 ACQUIRE: accepted interval bringing sample count to 3 -> LOCKED in same edge.
REQ-022 LOCKED: each accepted interval updates decodedValue <= majority(history including new bit) and pulses valid.
REQ-023 ACQUIRE->LOCKED edge SHALL also update decodedValue and pulse valid.
REQ-024 valid, decodedValue, isiCount registered at the same edge that samples the closing spike; valid low all other cycles.
REQ-025 Timeout: in ACQUIRE or LOCKED, no spike and cnt == TIMEOUT -> IDLE, history and sample count cleared, locked low next cycle.
REQ-026 Spike on the cycle cnt == TIMEOUT: spike takes priority; interval evaluated per REQ-016 (rejected at default parameters); no timeout.
REQ-027 decodedValue and isiCount hold their last values through timeout and IDLE.
REQ-028 errorFlag: set on rejected interval; cleared by clearError; set wins when both occur in the same cycle.
REQ-029 locked = (state == LOCKED), registered.

Reset
REQ-030 reset low at an edge: state IDLE, cnt 0, history 0, sample count 0, decodedValue 0, valid 0, locked 0, isiCount 0, errorFlag 0.
REQ-031 reset low overrides all inputs including spikeInput and clearError; reset mid-LOCKED drops lock the following cycle.

Verification
REQ-032 Spikes every 5 cycles after reset -> valid on 4th spike with decodedValue 1, locked 1, isiCount 5; valid on every later spike.
REQ-033 Spikes alternating intervals 9,10 -> decodedValue 0 after lock, isiCount tracks 9/10.
REQ-034 Locked on 1s, then intervals 10,10 -> decodedValue stays 1 after first 10, becomes 0 after second (majority).
REQ-035 Locked, then interval 2 -> errorFlag 1, no valid, locked stays 1; clearError pulse -> errorFlag 0; simultaneous reject+clearError -> errorFlag 1.
REQ-036 Locked, spikes stop -> locked 0 one cycle after cnt reaches 20, decodedValue held; next spikes re-lock after 3 accepted intervals.
REQ-037 reset low asserted mid-LOCKED with spike present -> all outputs per REQ-030 next cycle, no valid.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//
// Decodes a rate-coded spike train into a single bit. The gap between
// consecutive spikes is measured in clock cycles. Gaps in [M-1, N] are
// accepted and classified as 1 (gap <= THRESH) or 0 (gap > THRESH); any
// other gap is rejected and raises a sticky error. The last three accepted
// bits are majority-voted. After three accepted intervals the decoder locks
// and emits a decoded bit with every further accepted interval. Lock is
// dropped after TIMEOUT spike-free cycles. TIMEOUT must satisfy
// N < TIMEOUT < 31.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-low reset
//   spikeInput   spike train, one-cycle-high pulses
//   clearError   synchronous clear of errorFlag (a same-cycle set wins)
//   decodedValue majority-decoded bit, held between updates
//   valid        one-cycle pulse when decodedValue is updated
//   locked       high while in the LOCKED state
//   isiCount     last accepted inter-spike interval in cycles
//   errorFlag    sticky out-of-range interval indicator
module spike_rate_decoder #(
  parameter int M       = 5,
  parameter int N       = 10,
  parameter int THRESH  = 7,
  parameter int TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spikeInput,
  input  logic       clearError,
  output logic       decodedValue,
  output logic       valid,
  output logic       locked,
  output logic [4:0] isiCount,
  output logic       errorFlag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [4:0] ISI_MIN  = 5'(M - 1);
  localparam logic [4:0] ISI_MAX  = 5'(N);
  localparam logic [4:0] ISI_ONE  = 5'(THRESH);
  localparam logic [4:0] CNT_TOUT = 5'(TIMEOUT);
  localparam logic [4:0] CNT_SAT  = 5'd31;

  state_t     state_reg, state_next;
  logic [4:0] cnt_reg, cnt_next;
  logic [2:0] hist_reg, hist_next;
  logic [1:0] samp_reg, samp_next;
  logic       decoded_reg, decoded_next;
  logic       valid_reg, valid_next;
  logic       locked_reg, locked_next;
  logic [4:0] isi_reg, isi_next;
  logic       err_reg, err_next;

  // Interval classification. cnt_reg holds the cycles since the previous
  // spike, so it is the measured interval on a spike cycle.
  logic       isi_accept;
  logic       isi_bit;
  logic [2:0] hist_shift;
  logic       hist_major;

  assign isi_accept = (cnt_reg >= ISI_MIN) && (cnt_reg <= ISI_MAX);
  assign isi_bit    = (cnt_reg <= ISI_ONE);
  assign hist_shift = {hist_reg[1:0], isi_bit};
  // Majority over the history including the bit being shifted in.
  assign hist_major = (hist_shift[0] & hist_shift[1]) |
                      (hist_shift[0] & hist_shift[2]) |
                      (hist_shift[1] & hist_shift[2]);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 5'd0;
      hist_reg    <= 3'd0;
      samp_reg    <= 2'd0;
      decoded_reg <= 1'b0;
      valid_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      isi_reg     <= 5'd0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hist_reg    <= hist_next;
      samp_reg    <= samp_next;
      decoded_reg <= decoded_next;
      valid_reg   <= valid_next;
      locked_reg  <= locked_next;
      isi_reg     <= isi_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hist_next    = hist_reg;
    samp_next    = samp_reg;
    decoded_next = decoded_reg;
    valid_next   = 1'b0;
    isi_next     = isi_reg;
    err_next     = clearError ? 1'b0 : err_reg;

    case (state_reg)
      IDLE: begin
        // The first spike only starts the interval clock; there is no
        // previous spike to measure against.
        if (spikeInput) begin
          state_next = ACQUIRE;
          cnt_next   = 5'd1;
          hist_next  = 3'd0;
          samp_next  = 2'd0;
        end else begin
          cnt_next = 5'd0;
        end
      end

      ACQUIRE, LOCKED: begin
        if (spikeInput) begin
          // A spike always wins over the timeout, even when cnt == TIMEOUT.
          cnt_next = 5'd1;
          if (isi_accept) begin
            isi_next  = cnt_reg;
            hist_next = hist_shift;
            samp_next = (samp_reg == 2'd3) ? 2'd3 : samp_reg + 2'd1;
            if (state_reg == LOCKED || samp_reg == 2'd2) begin
              state_next   = LOCKED;
              decoded_next = hist_major;
              valid_next   = 1'b1;
            end
          end else begin
            // Rejected gap: only the error flag and the interval clock move.
            err_next = 1'b1;
          end
        end else if (cnt_reg == CNT_TOUT) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
          hist_next  = 3'd0;
          samp_next  = 2'd0;
        end else begin
          cnt_next = (cnt_reg == CNT_SAT) ? CNT_SAT : cnt_reg + 5'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 5'd0;
        hist_next  = 3'd0;
        samp_next  = 2'd0;
      end
    endcase

    locked_next = (state_next == LOCKED);
  end

  // Outputs
  always_comb begin
    decodedValue = decoded_reg;
    valid        = valid_reg;
    locked       = locked_reg;
    isiCount     = isi_reg;
    errorFlag    = err_reg;
  end

endmodule
